// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the alu_arbiter slice.
//            Contains the ALU opcode encodings, the FSM state encoding and
//            the response-owner encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcode encodings
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Which requester owns the in-flight op, also used as the RR pointer
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational WIDTH-bit ALU (and/or/add/sub/slt/nor/xor).
//            Unknown opcodes yield zero. ADD/SUB wrap, carry-out discarded.
// Ports    : i_op  [OP_W]  opcode
//            i_x   [WIDTH] first operand
//            i_y   [WIDTH] second operand
//            o_z   [WIDTH] result
//            o_ovf [1]     signed overflow of ADD/SUB (ALU_OVERFLOW_EN only)
// Config   : `define ALU_OVERFLOW_EN adds the o_ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
`ifdef ALU_OVERFLOW_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_z
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;

    assign w_sum  = i_x + i_y;
    assign w_diff = i_x - i_y;
    assign w_slt  = $signed(i_x) < $signed(i_y);

    always_comb begin
        o_z = '0;
        case (i_op)
            OP_W'(OP_AND): o_z = i_x & i_y;
            OP_W'(OP_OR):  o_z = i_x | i_y;
            OP_W'(OP_ADD): o_z = w_sum;
            OP_W'(OP_SUB): o_z = w_diff;
            OP_W'(OP_SLT): o_z = {{(WIDTH-1){1'b0}}, w_slt};
            OP_W'(OP_NOR): o_z = ~(i_x | i_y);
            OP_W'(OP_XOR): o_z = i_x ^ i_y;
            default:       o_z = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow: operands' signs (y inverted for SUB) agree, result differs
    always_comb begin
        o_ovf = 1'b0;
        if (i_op == OP_W'(OP_ADD)) begin
            o_ovf = (i_x[WIDTH-1] == i_y[WIDTH-1]) && (w_sum[WIDTH-1] != i_x[WIDTH-1]);
        end else if (i_op == OP_W'(OP_SUB)) begin
            o_ovf = (i_x[WIDTH-1] != i_y[WIDTH-1]) && (w_diff[WIDTH-1] != i_x[WIDTH-1]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between requesters A and B with a
//            round-robin grant, valid/ready request and response handshakes,
//            and registered operands/result. One op in flight at a time.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            {a,b}_req_valid/ready     request handshake
//            {a,b}_req_op/x/y          opcode and operands
//            {a,b}_rsp_valid/ready     response handshake
//            {a,b}_rsp_z               result (shared result register)
//            {a,b}_rsp_ovf             signed ADD/SUB overflow (ALU_OVERFLOW_EN)
//            busy                      controller not idle
// Config   : `define ALU_OVERFLOW_EN adds the *_rsp_ovf outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [OP_W-1:0]  a_req_op,
    input  logic [WIDTH-1:0] a_req_x,
    input  logic [WIDTH-1:0] a_req_y,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic [WIDTH-1:0] a_rsp_z,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [OP_W-1:0]  b_req_op,
    input  logic [WIDTH-1:0] b_req_x,
    input  logic [WIDTH-1:0] b_req_y,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] b_rsp_z,
`ifdef ALU_OVERFLOW_EN
    output logic             a_rsp_ovf,
    output logic             b_rsp_ovf,
`endif
    output logic             busy
);

    state_t           state_q, state_d;
    owner_t           ptr_q,   ptr_d;
    owner_t           owner_q, owner_d;
    logic [OP_W-1:0]  op_q,    op_d;
    logic [WIDTH-1:0] x_q,     x_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic [WIDTH-1:0] z_q,     z_d;
    logic [WIDTH-1:0] w_alu_z;
    logic             w_grant_b;
    logic             w_rsp_done;

`ifdef ALU_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic w_alu_ovf;
`endif

    alu_core #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_alu_core (
        .i_op  (op_q),
        .i_x   (x_q),
        .i_y   (y_q),
`ifdef ALU_OVERFLOW_EN
        .o_ovf (w_alu_ovf),
`endif
        .o_z   (w_alu_z)
    );

    // B wins if it is the only requester, or on contention when the pointer is B
    assign w_grant_b  = b_req_valid && (!a_req_valid || (ptr_q == OWNER_B));
    assign w_rsp_done = (owner_q == OWNER_A) ? a_rsp_ready : b_rsp_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
`ifdef ALU_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Handshakes are masked while rst is high since they would be discarded
                a_req_ready = !rst && a_req_valid && !w_grant_b;
                b_req_ready = !rst && w_grant_b;
                if (a_req_ready) begin
                    owner_d = OWNER_A;
                    ptr_d   = OWNER_B;
                    op_d    = a_req_op;
                    x_d     = a_req_x;
                    y_d     = a_req_y;
                    state_d = S_EXEC;
                end else if (b_req_ready) begin
                    owner_d = OWNER_B;
                    ptr_d   = OWNER_A;
                    op_d    = b_req_op;
                    x_d     = b_req_x;
                    y_d     = b_req_y;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                z_d     = w_alu_z;
`ifdef ALU_OVERFLOW_EN
                ovf_d   = w_alu_ovf;
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                a_rsp_valid = !rst && (owner_q == OWNER_A);
                b_rsp_valid = !rst && (owner_q == OWNER_B);
                // Only the owner's rsp_ready can close the response
                if (w_rsp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= OWNER_A;
            owner_q <= OWNER_A;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
`ifdef ALU_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
`ifdef ALU_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign a_rsp_z = z_q;
    assign b_rsp_z = z_q;
    assign busy    = (state_q != S_IDLE);

`ifdef ALU_OVERFLOW_EN
    assign a_rsp_ovf = ovf_q;
    assign b_rsp_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter: table of single-requester
//            ALU vectors plus hand-written contention, stall and reset
//            sequences.
// Config   : `define ALU_OVERFLOW_EN also checks the *_rsp_ovf outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int OP_W  = 4;

    logic             clk;
    logic             rst;
    logic             a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic             b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [OP_W-1:0]  a_req_op, b_req_op;
    logic [WIDTH-1:0] a_req_x, a_req_y, b_req_x, b_req_y;
    logic [WIDTH-1:0] a_rsp_z, b_rsp_z;
    logic             busy;
`ifdef ALU_OVERFLOW_EN
    logic             a_rsp_ovf, b_rsp_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_op    (a_req_op),
        .a_req_x     (a_req_x),
        .a_req_y     (a_req_y),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_z     (a_rsp_z),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_op    (b_req_op),
        .b_req_x     (b_req_x),
        .b_req_y     (b_req_y),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_z     (b_rsp_z),
`ifdef ALU_OVERFLOW_EN
        .a_rsp_ovf   (a_rsp_ovf),
        .b_rsp_ovf   (b_rsp_ovf),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from one side (side 0 = A, 1 = B), with the
    // response ready raised early during EXEC, where it must be ignored.
    task automatic do_txn(input logic side, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z, input logic ovf,
                          input string tag);
        if (!side) begin
            a_req_valid = 1'b1; a_req_op = op; a_req_x = x; a_req_y = y;
        end else begin
            b_req_valid = 1'b1; b_req_op = op; b_req_x = x; b_req_y = y;
        end
        #1;
        check({tag, "_ready"},       side ? b_req_ready : a_req_ready, 1);
        check({tag, "_other_ready"}, side ? a_req_ready : b_req_ready, 0);
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        if (!side) a_rsp_ready = 1'b1; else b_rsp_ready = 1'b1;
        #1;
        check({tag, "_exec_busy"},  busy, 1);
        check({tag, "_exec_rspv"},  {a_rsp_valid, b_rsp_valid}, 2'b00);
        step();
        check({tag, "_rsp_valid"},  {a_rsp_valid, b_rsp_valid}, side ? 2'b01 : 2'b10);
        check({tag, "_z"},          side ? b_rsp_z : a_rsp_z, z);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"},        side ? b_rsp_ovf : a_rsp_ovf, ovf);
`else
        if (ovf === 1'bx) check({tag, "_ovf_x"}, ovf, 0);
`endif
        step();
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        #1;
        check({tag, "_done_busy"},  busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_AND, 32'h0000_00F0, 32'h0000_00CC, 32'h0000_00C0, 1'b0};
        vecs[1]  = '{OP_OR,  32'h0000_00F0, 32'h0000_000C, 32'h0000_00FC, 1'b0};
        vecs[2]  = '{OP_ADD, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vecs[3]  = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[5]  = '{OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{OP_XOR, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, 1'b0};
        vecs[8]  = '{4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[9]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[10] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[11] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[12] = '{OP_AND, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0};

        rst = 1'b1;
        a_req_valid = 1'b1; a_req_op = '0; a_req_x = '0; a_req_y = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_op = '0; b_req_x = '0; b_req_y = '0; b_rsp_ready = 1'b0;
        step();
        step();
        check("reset_req_ready", {a_req_ready, b_req_ready}, 2'b00);
        check("reset_rsp_valid", {a_rsp_valid, b_rsp_valid}, 2'b00);
        check("reset_busy",      busy, 0);
        check("reset_z",         a_rsp_z, 0);
        a_req_valid = 1'b0;
        rst = 1'b0;
        step();

        // Table: alternate sides so both datapaths see every vector
        for (int i = 0; i < 13; i++) begin
            do_txn(i[0], vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ovf,
                   $sformatf("vec%0d", i));
        end

        // Contention from a fresh reset: A first, then B, then pointer back to A
        rst = 1'b1; step(); rst = 1'b0;
        a_req_valid = 1'b1; a_req_op = OP_ADD; a_req_x = 32'd5; a_req_y = 32'd7;
        b_req_valid = 1'b1; b_req_op = OP_SUB; b_req_x = 32'd3; b_req_y = 32'd5;
        #1;
        check("cont_a_wins", {a_req_ready, b_req_ready}, 2'b10);
        step();
        a_req_valid = 1'b0;
        #1;
        check("cont_exec_b_ready", b_req_ready, 0);
        step();
        b_rsp_ready = 1'b1;
        #1;
        check("cont_a_rsp_valid", a_rsp_valid, 1);
        check("cont_a_z",         a_rsp_z, 32'd12);
        check("cont_resp_b_ready", b_req_ready, 0);
        step();
        check("cont_nonowner_ignored", a_rsp_valid, 1);
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b0;
        step();
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_op = OP_AND; a_req_x = 32'hFF; a_req_y = 32'h0F;
        #1;
        check("cont_b_wins_ptr", {a_req_ready, b_req_ready}, 2'b01);
        step();
        b_req_valid = 1'b0;
        step();
        check("cont_b_rsp_valid", b_rsp_valid, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d_b_z", i),     b_rsp_z, 32'hFFFF_FFFE);
            check($sformatf("hold%0d_b_valid", i), {a_rsp_valid, b_rsp_valid}, 2'b01);
            check($sformatf("hold%0d_ready", i),   {a_req_ready, b_req_ready}, 2'b00);
            step();
        end
        b_rsp_ready = 1'b1;
        step();
        b_rsp_ready = 1'b0;
        #1;
        check("resume_a_ready", a_req_ready, 1);
        step();
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        step();
        check("resume_a_rsp_valid", a_rsp_valid, 1);
        check("resume_a_z",         a_rsp_z, 32'h0F);
        step();
        a_rsp_ready = 1'b0;
        check("resume_done_busy", busy, 0);

        // Reset during EXEC discards the op
        a_req_valid = 1'b1; a_req_op = OP_ADD; a_req_x = 32'd1; a_req_y = 32'd2;
        #1;
        check("rstmid_accept", a_req_ready, 1);
        step();
        a_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rstmid_busy",      busy, 0);
        check("rstmid_rsp_valid", {a_rsp_valid, b_rsp_valid}, 2'b00);
        check("rstmid_req_ready", {a_req_ready, b_req_ready}, 2'b00);
        check("rstmid_z",         b_rsp_z, 0);
        step();
        step();
        check("rstmid_no_rsp", {a_rsp_valid, b_rsp_valid, busy}, 3'b000);
        do_txn(1'b1, OP_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, "rstmid_b");

        // Pointer returns to A on reset; valid dropped before the edge is not taken
        a_req_valid = 1'b1; a_req_op = OP_AND;
        #1;
        check("ptr_pre_a_ready", a_req_ready, 1);
        step();
        a_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        #1;
        check("ptr_reset_to_a", {a_req_ready, b_req_ready}, 2'b10);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        step();
        check("drop_valid_no_accept", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
